// File: rtl/bp_io_load_arbiter.sv
// Purpose: round-robin arbiter sharing the unicore inbound I/O load port between NBF (src 0) and Ethernet DMA (src 1).
// Latency: zero-cycle combinational command and response paths; a response tag becomes routable the cycle after its push.
// Backpressure: commands stall while the tag FIFO is full; responses stall on the addressed requester's ready_and.
module bp_io_load_arbiter #(
    parameter int msg_width_p = 0,
    parameter int els_p       = 4
) (
    input  logic                       clk_i,
    input  logic                       reset_i,

    input  logic [msg_width_p-1:0]     nbf_cmd_i,
    input  logic                       nbf_cmd_v_i,
    output logic                       nbf_cmd_yumi_o,
    output logic [msg_width_p-1:0]     nbf_resp_o,
    output logic                       nbf_resp_v_o,
    input  logic                       nbf_resp_ready_and_i,

    input  logic [msg_width_p-1:0]     eth_cmd_i,
    input  logic                       eth_cmd_v_i,
    output logic                       eth_cmd_yumi_o,
    output logic [msg_width_p-1:0]     eth_resp_o,
    output logic                       eth_resp_v_o,
    input  logic                       eth_resp_ready_and_i,

    output logic [msg_width_p-1:0]     io_cmd_o,
    output logic                       io_cmd_v_o,
    input  logic                       io_cmd_yumi_i,
    input  logic [msg_width_p-1:0]     io_resp_i,
    input  logic                       io_resp_v_i,
    output logic                       io_resp_ready_and_o,

    output logic [$clog2(els_p+1)-1:0] outstanding_o,
    output logic                       unexpected_resp_o
);

    localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int cnt_w_lp = $clog2(els_p + 1);

    // Arbitration history and the in-order source-tag FIFO
    logic                 last_grant_r;
    logic [els_p-1:0]     tag_r;
    logic [ptr_w_lp-1:0]  wr_ptr_r;
    logic [ptr_w_lp-1:0]  rd_ptr_r;
    logic [cnt_w_lp-1:0]  count_r;
    logic                 unexpected_r;

    logic full;
    logic empty;
    logic grant_v;
    logic grant_src;
    logic head;
    logic sel_ready;
    logic push;
    logic pop;

    assign full  = (count_r == cnt_w_lp'(els_p));
    assign empty = (count_r == '0);
    assign head  = tag_r[rd_ptr_r];

    // Round-robin grant: a tie goes to the source not granted last; nothing is granted while full or in reset
    always_comb begin
        grant_v   = 1'b0;
        grant_src = 1'b0;
        if (!reset_i && !full) begin
            if (nbf_cmd_v_i && eth_cmd_v_i) begin
                grant_v   = 1'b1;
                grant_src = ~last_grant_r;
            end else if (nbf_cmd_v_i) begin
                grant_v   = 1'b1;
                grant_src = 1'b0;
            end else if (eth_cmd_v_i) begin
                grant_v   = 1'b1;
                grant_src = 1'b1;
            end
        end
    end

    assign io_cmd_o       = grant_src ? eth_cmd_i : nbf_cmd_i;
    assign io_cmd_v_o     = grant_v;
    assign push           = grant_v & io_cmd_yumi_i;
    assign nbf_cmd_yumi_o = push & ~grant_src;
    assign eth_cmd_yumi_o = push &  grant_src;

    // Responses follow the oldest outstanding tag, never the message contents
    assign sel_ready           = head ? eth_resp_ready_and_i : nbf_resp_ready_and_i;
    assign io_resp_ready_and_o = ~reset_i & ~empty & sel_ready;
    assign nbf_resp_v_o        = ~reset_i & io_resp_v_i & ~empty & ~head;
    assign eth_resp_v_o        = ~reset_i & io_resp_v_i & ~empty &  head;
    assign nbf_resp_o          = io_resp_i;
    assign eth_resp_o          = io_resp_i;
    assign pop                 = io_resp_v_i & io_resp_ready_and_o;

    assign outstanding_o     = count_r;
    assign unexpected_resp_o = unexpected_r;

    // Tag FIFO push/pop, grant history and sticky unexpected-response flag
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            last_grant_r <= 1'b1;
            wr_ptr_r     <= '0;
            rd_ptr_r     <= '0;
            count_r      <= '0;
            unexpected_r <= 1'b0;
        end else begin
            if (push) begin
                tag_r[wr_ptr_r] <= grant_src;
                wr_ptr_r        <= (wr_ptr_r == ptr_w_lp'(els_p - 1)) ? '0 : wr_ptr_r + 1'b1;
                last_grant_r    <= grant_src;
            end
            if (pop) begin
                rd_ptr_r <= (rd_ptr_r == ptr_w_lp'(els_p - 1)) ? '0 : rd_ptr_r + 1'b1;
            end
            count_r <= count_r + cnt_w_lp'(push) - cnt_w_lp'(pop);
            if (io_resp_v_i && empty) begin
                unexpected_r <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bp_io_load_arbiter.sv
// Purpose: directed scoreboard bench for bp_io_load_arbiter.
// Latency: inputs driven 1 time unit after posedge; monitor samples on negedge.
// Backpressure: responses and commands handshake only when the bench asserts yumi/ready.
module tb_bp_io_load_arbiter;

    localparam int MW  = 16;
    localparam int ELS = 4;

    logic          clk_i;
    logic          reset_i;
    logic [MW-1:0] nbf_cmd_i, eth_cmd_i, io_resp_i;
    logic          nbf_cmd_v_i, eth_cmd_v_i, io_cmd_yumi_i, io_resp_v_i;
    logic          nbf_resp_ready_and_i, eth_resp_ready_and_i;
    logic [MW-1:0] nbf_resp_o, eth_resp_o, io_cmd_o;
    logic          nbf_cmd_yumi_o, eth_cmd_yumi_o, nbf_resp_v_o, eth_resp_v_o;
    logic          io_cmd_v_o, io_resp_ready_and_o, unexpected_resp_o;
    logic [$clog2(ELS+1)-1:0] outstanding_o;

    bp_io_load_arbiter #(.msg_width_p(MW), .els_p(ELS)) dut (
        .clk_i                (clk_i),
        .reset_i              (reset_i),
        .nbf_cmd_i            (nbf_cmd_i),
        .nbf_cmd_v_i          (nbf_cmd_v_i),
        .nbf_cmd_yumi_o       (nbf_cmd_yumi_o),
        .nbf_resp_o           (nbf_resp_o),
        .nbf_resp_v_o         (nbf_resp_v_o),
        .nbf_resp_ready_and_i (nbf_resp_ready_and_i),
        .eth_cmd_i            (eth_cmd_i),
        .eth_cmd_v_i          (eth_cmd_v_i),
        .eth_cmd_yumi_o       (eth_cmd_yumi_o),
        .eth_resp_o           (eth_resp_o),
        .eth_resp_v_o         (eth_resp_v_o),
        .eth_resp_ready_and_i (eth_resp_ready_and_i),
        .io_cmd_o             (io_cmd_o),
        .io_cmd_v_o           (io_cmd_v_o),
        .io_cmd_yumi_i        (io_cmd_yumi_i),
        .io_resp_i            (io_resp_i),
        .io_resp_v_i          (io_resp_v_i),
        .io_resp_ready_and_o  (io_resp_ready_and_o),
        .outstanding_o        (outstanding_o),
        .unexpected_resp_o    (unexpected_resp_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef enum int {K_OUT, K_UNEXP, K_CMDV, K_NYUMI, K_EYUMI, K_RRDY, K_NRV, K_ERV} kind_e;
    typedef struct { kind_e kind; logic [31:0] exp; } chk_t;
    typedef struct { logic src; logic [MW-1:0] dat; } xact_t;

    chk_t  chk_q[$];
    xact_t cmd_q[$];
    xact_t resp_q[$];

    int    n_run  = 0;
    int    n_fail = 0;
    logic  done   = 1'b0;

    chk_t        cur;
    xact_t       ex;
    logic [31:0] act;

    function automatic string kname(kind_e k);
        case (k)
            K_OUT:   return "outstanding_o";
            K_UNEXP: return "unexpected_resp_o";
            K_CMDV:  return "io_cmd_v_o";
            K_NYUMI: return "nbf_cmd_yumi_o";
            K_EYUMI: return "eth_cmd_yumi_o";
            K_RRDY:  return "io_resp_ready_and_o";
            K_NRV:   return "nbf_resp_v_o";
            default: return "eth_resp_v_o";
        endcase
    endfunction

    function automatic logic [31:0] actual(kind_e k);
        case (k)
            K_OUT:   return 32'(outstanding_o);
            K_UNEXP: return 32'(unexpected_resp_o);
            K_CMDV:  return 32'(io_cmd_v_o);
            K_NYUMI: return 32'(nbf_cmd_yumi_o);
            K_EYUMI: return 32'(eth_cmd_yumi_o);
            K_RRDY:  return 32'(io_resp_ready_and_o);
            K_NRV:   return 32'(nbf_resp_v_o);
            default: return 32'(eth_resp_v_o);
        endcase
    endfunction

    task automatic expect_k(input kind_e k, input logic [31:0] v);
        chk_t c;
        c.kind = k;
        c.exp  = v;
        chk_q.push_back(c);
    endtask

    task automatic exp_cmd(input logic src, input logic [MW-1:0] dat);
        xact_t x;
        x.src = src;
        x.dat = dat;
        cmd_q.push_back(x);
    endtask

    task automatic exp_resp(input logic dst, input logic [MW-1:0] dat);
        xact_t x;
        x.src = dst;
        x.dat = dat;
        resp_q.push_back(x);
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_inputs();
        nbf_cmd_i = '0; eth_cmd_i = '0; io_resp_i = '0;
        nbf_cmd_v_i = 1'b0; eth_cmd_v_i = 1'b0;
        io_cmd_yumi_i = 1'b0; io_resp_v_i = 1'b0;
        nbf_resp_ready_and_i = 1'b0; eth_resp_ready_and_i = 1'b0;
    endtask

    // Reset with every input active; all handshake outputs must stay low
    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            cyc();
            reset_i = 1'b1;
            nbf_cmd_v_i = 1'b1; eth_cmd_v_i = 1'b1; io_cmd_yumi_i = 1'b1;
            io_resp_v_i = 1'b1; nbf_resp_ready_and_i = 1'b1; eth_resp_ready_and_i = 1'b1;
            expect_k(K_CMDV, 0);
            expect_k(K_NYUMI, 0);
            expect_k(K_EYUMI, 0);
            expect_k(K_RRDY, 0);
            expect_k(K_NRV, 0);
            expect_k(K_ERV, 0);
            if (i > 0) begin
                expect_k(K_OUT, 0);
                expect_k(K_UNEXP, 0);
            end
        end
        cyc();
        reset_i = 1'b0;
        clear_inputs();
        expect_k(K_OUT, 0);
        expect_k(K_UNEXP, 0);
    endtask

    // Monitor: evaluates queued checks and scores every handshake against the scoreboards
    always @(negedge clk_i) begin
        while (chk_q.size() > 0) begin
            cur = chk_q.pop_front();
            act = actual(cur.kind);
            n_run++;
            if (act !== cur.exp) begin
                n_fail++;
                $display("FAIL %s: got %0h, expected %0h at %0t", kname(cur.kind), act, cur.exp, $time);
            end
        end
        if (io_cmd_v_o === 1'b1 && io_cmd_yumi_i === 1'b1) begin
            n_run++;
            if (cmd_q.size() == 0) begin
                n_fail++;
                $display("FAIL cmd_handshake: got unexpected command %0h, expected none at %0t", io_cmd_o, $time);
            end else begin
                ex = cmd_q.pop_front();
                if ({eth_cmd_yumi_o, nbf_cmd_yumi_o} !== (ex.src ? 2'b10 : 2'b01) || io_cmd_o !== ex.dat) begin
                    n_fail++;
                    $display("FAIL cmd_grant: got yumi(eth,nbf)=%b dat=%0h, expected src=%0d dat=%0h at %0t",
                             {eth_cmd_yumi_o, nbf_cmd_yumi_o}, io_cmd_o, ex.src, ex.dat, $time);
                end
            end
        end
        if (io_resp_v_i === 1'b1 && io_resp_ready_and_o === 1'b1) begin
            n_run++;
            if (resp_q.size() == 0) begin
                n_fail++;
                $display("FAIL resp_handshake: got unexpected response %0h, expected none at %0t", io_resp_i, $time);
            end else begin
                ex = resp_q.pop_front();
                if ({eth_resp_v_o, nbf_resp_v_o} !== (ex.src ? 2'b10 : 2'b01) ||
                    (ex.src ? eth_resp_o : nbf_resp_o) !== ex.dat) begin
                    n_fail++;
                    $display("FAIL resp_route: got v(eth,nbf)=%b dat=%0h, expected dst=%0d dat=%0h at %0t",
                             {eth_resp_v_o, nbf_resp_v_o}, io_resp_i, ex.src, ex.dat, $time);
                end
            end
        end
        if (done) begin
            n_run++;
            if (cmd_q.size() != 0 || resp_q.size() != 0) begin
                n_fail++;
                $display("FAIL leftover: got %0d cmds %0d resps pending, expected 0 0", cmd_q.size(), resp_q.size());
            end
            $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
            $finish;
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    // Directed stimulus
    initial begin
        clear_inputs();
        reset_i = 1'b1;
        do_reset(2);

        // Single NBF command, response held off by NBF ready, then delivered
        cyc(); nbf_cmd_v_i = 1'b1; nbf_cmd_i = 16'hA001; io_cmd_yumi_i = 1'b1;
        exp_cmd(1'b0, 16'hA001);
        expect_k(K_CMDV, 1); expect_k(K_NYUMI, 1); expect_k(K_EYUMI, 0); expect_k(K_OUT, 0);
        cyc(); clear_inputs();
        expect_k(K_OUT, 1); expect_k(K_CMDV, 0);
        cyc(); cyc();
        cyc(); io_resp_v_i = 1'b1; io_resp_i = 16'h5001; eth_resp_ready_and_i = 1'b1;
        expect_k(K_NRV, 1); expect_k(K_ERV, 0); expect_k(K_RRDY, 0);
        cyc(); nbf_resp_ready_and_i = 1'b1;
        exp_resp(1'b0, 16'h5001);
        expect_k(K_RRDY, 1); expect_k(K_NRV, 1); expect_k(K_ERV, 0);
        cyc(); clear_inputs();
        expect_k(K_OUT, 0);

        // Both requesting every cycle after reset: strict alternation, NBF first
        do_reset(2);
        for (int i = 0; i <= 6; i++) begin
            cyc(); clear_inputs();
            if (i < 6) begin
                nbf_cmd_v_i = 1'b1; eth_cmd_v_i = 1'b1; io_cmd_yumi_i = 1'b1;
                nbf_cmd_i = 16'hA100 + 16'(i);
                eth_cmd_i = 16'hE100 + 16'(i);
                exp_cmd(1'(i % 2), (i % 2 == 1) ? 16'hE100 + 16'(i) : 16'hA100 + 16'(i));
                expect_k(K_NYUMI, (i % 2 == 0) ? 1 : 0);
                expect_k(K_EYUMI, (i % 2 == 1) ? 1 : 0);
            end
            if (i >= 1) begin
                io_resp_v_i = 1'b1; io_resp_i = 16'h5100 + 16'(i);
                nbf_resp_ready_and_i = 1'b1; eth_resp_ready_and_i = 1'b1;
                exp_resp(1'((i - 1) % 2), 16'h5100 + 16'(i));
            end
        end
        cyc(); clear_inputs();
        expect_k(K_OUT, 0);

        // Fill the tag FIFO; full blocks commands even with a same-cycle pop
        for (int i = 0; i < 4; i++) begin
            cyc(); clear_inputs();
            nbf_cmd_v_i = 1'b1; io_cmd_yumi_i = 1'b1; nbf_cmd_i = 16'hA200 + 16'(i);
            exp_cmd(1'b0, 16'hA200 + 16'(i));
        end
        cyc(); clear_inputs();
        nbf_cmd_v_i = 1'b1; nbf_cmd_i = 16'hA204;
        io_resp_v_i = 1'b1; io_resp_i = 16'h5200; nbf_resp_ready_and_i = 1'b1;
        exp_resp(1'b0, 16'h5200);
        expect_k(K_OUT, 4); expect_k(K_CMDV, 0); expect_k(K_NYUMI, 0); expect_k(K_RRDY, 1);
        cyc(); clear_inputs();
        nbf_cmd_v_i = 1'b1; nbf_cmd_i = 16'hA204; io_cmd_yumi_i = 1'b1;
        exp_cmd(1'b0, 16'hA204);
        expect_k(K_CMDV, 1); expect_k(K_OUT, 3);
        for (int i = 1; i <= 4; i++) begin
            cyc(); clear_inputs();
            io_resp_v_i = 1'b1; io_resp_i = 16'h5200 + 16'(i); nbf_resp_ready_and_i = 1'b1;
            exp_resp(1'b0, 16'h5200 + 16'(i));
            if (i == 1) expect_k(K_OUT, 4);
        end
        cyc(); clear_inputs();
        expect_k(K_OUT, 0);

        // Tags ETH, NBF, ETH; ETH not ready must block the head without reordering
        cyc(); clear_inputs(); eth_cmd_v_i = 1'b1; eth_cmd_i = 16'hE300; io_cmd_yumi_i = 1'b1;
        exp_cmd(1'b1, 16'hE300);
        cyc(); clear_inputs(); nbf_cmd_v_i = 1'b1; nbf_cmd_i = 16'hA301; io_cmd_yumi_i = 1'b1;
        exp_cmd(1'b0, 16'hA301);
        cyc(); clear_inputs(); eth_cmd_v_i = 1'b1; eth_cmd_i = 16'hE302; io_cmd_yumi_i = 1'b1;
        exp_cmd(1'b1, 16'hE302);
        for (int i = 0; i < 3; i++) begin
            cyc(); clear_inputs();
            io_resp_v_i = 1'b1; io_resp_i = 16'h5300; nbf_resp_ready_and_i = 1'b1;
            expect_k(K_RRDY, 0); expect_k(K_ERV, 1); expect_k(K_NRV, 0); expect_k(K_OUT, 3);
        end
        cyc(); io_resp_v_i = 1'b1; io_resp_i = 16'h5300; nbf_resp_ready_and_i = 1'b1; eth_resp_ready_and_i = 1'b1;
        exp_resp(1'b1, 16'h5300);
        cyc(); io_resp_i = 16'h5301; exp_resp(1'b0, 16'h5301);
        cyc(); io_resp_i = 16'h5302; exp_resp(1'b1, 16'h5302);
        cyc(); clear_inputs();
        expect_k(K_OUT, 0);

        // Response with nothing outstanding: refused, sticky error raised
        cyc(); clear_inputs();
        io_resp_v_i = 1'b1; io_resp_i = 16'h5400; nbf_resp_ready_and_i = 1'b1; eth_resp_ready_and_i = 1'b1;
        expect_k(K_RRDY, 0); expect_k(K_NRV, 0); expect_k(K_ERV, 0); expect_k(K_UNEXP, 0);
        cyc(); clear_inputs();
        expect_k(K_UNEXP, 1);
        cyc(); cyc();
        expect_k(K_UNEXP, 1);

        // Reset with three tags in flight, then first tie goes to NBF
        cyc(); clear_inputs(); nbf_cmd_v_i = 1'b1; nbf_cmd_i = 16'hA500; io_cmd_yumi_i = 1'b1;
        exp_cmd(1'b0, 16'hA500);
        cyc(); clear_inputs(); eth_cmd_v_i = 1'b1; eth_cmd_i = 16'hE501; io_cmd_yumi_i = 1'b1;
        exp_cmd(1'b1, 16'hE501);
        cyc(); clear_inputs(); nbf_cmd_v_i = 1'b1; nbf_cmd_i = 16'hA502; io_cmd_yumi_i = 1'b1;
        exp_cmd(1'b0, 16'hA502);
        cyc(); clear_inputs();
        expect_k(K_OUT, 3); expect_k(K_UNEXP, 1);
        do_reset(2);
        cyc(); nbf_cmd_v_i = 1'b1; eth_cmd_v_i = 1'b1; io_cmd_yumi_i = 1'b1;
        nbf_cmd_i = 16'hA600; eth_cmd_i = 16'hE600;
        exp_cmd(1'b0, 16'hA600);
        expect_k(K_NYUMI, 1); expect_k(K_EYUMI, 0);
        cyc(); clear_inputs();
        io_resp_v_i = 1'b1; io_resp_i = 16'h5600; nbf_resp_ready_and_i = 1'b1;
        exp_resp(1'b0, 16'h5600);
        cyc(); clear_inputs();
        expect_k(K_OUT, 0);

        cyc();
        done = 1'b1;
    end

endmodule
